// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch FSM, skid register, redirect latch, IF/ID register
// Optional macro IF_STAGE_FLUSH_EN: squash the instruction accepted while a redirect is active.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  if_pc_source,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic        hazard,
    input  logic        pstop_i,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_next_i_addr,
    output logic        if_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_skid;
    logic [31:0] r_redir_pc;
    logic        r_redir_pending;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_nia;

    logic        w_stall;
    logic        w_src_active;
    logic [31:0] w_src_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_accept;
    logic [31:0] w_fetched;
    logic [31:0] w_slot_instr;

    assign w_stall      = hazard | pstop_i;
    // Source 3 is an undefined encoding and behaves as sequential fetch.
    assign w_src_active = (if_pc_source == 2'd1) || (if_pc_source == 2'd2);
    assign w_src_target = (if_pc_source == 2'd1) ? branch_addr : jump_addr;
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_next_pc    = w_src_active    ? w_src_target :
                          r_redir_pending ? r_redir_pc   : w_pc_plus4;

    assign w_accept  = !w_stall && (((r_state == ST_FETCH) && imem_ack) || (r_state == ST_HOLD));
    assign w_fetched = (r_state == ST_HOLD) ? r_skid : imem_rdata;

`ifdef IF_STAGE_FLUSH_EN
    assign w_slot_instr = (w_src_active || r_redir_pending) ? 32'h0 : w_fetched;
`else
    assign w_slot_instr = w_fetched;
`endif

    assign imem_req          = (r_state == ST_FETCH);
    assign imem_addr         = r_pc;
    assign if_busy           = (r_state == ST_FETCH) && !imem_ack;
    assign IF_ID_instruction = r_if_id_instr;
    assign IF_ID_next_i_addr = r_if_id_nia;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pc            <= RESET_PC;
            r_skid          <= 32'h0;
            r_redir_pc      <= 32'h0;
            r_redir_pending <= 1'b0;
            r_if_id_instr   <= 32'h0;
            r_if_id_nia     <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (!w_stall) begin
                            r_if_id_instr <= w_slot_instr;
                            r_if_id_nia   <= w_pc_plus4;
                            r_pc          <= w_next_pc;
                        end else begin
                            r_skid  <= imem_rdata;
                            r_state <= ST_HOLD;
                        end
                    end else if (!w_stall) begin
                        r_if_id_instr <= 32'h0;
                    end
                end
                ST_HOLD: begin
                    if (!w_stall) begin
                        r_if_id_instr <= w_slot_instr;
                        r_if_id_nia   <= w_pc_plus4;
                        r_pc          <= w_next_pc;
                        r_state       <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Acceptance consumes any redirect, including one arriving this same cycle.
            if (w_accept) begin
                r_redir_pending <= 1'b0;
            end else if (w_src_active && !pstop_i) begin
                r_redir_pc      <= w_src_target;
                r_redir_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage: directed vector table, reset corner, randomized run vs model
module tb_if_stage;

`ifdef IF_STAGE_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  if_pc_source = 2'd0;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] jump_addr = 32'h0;
    logic        hazard = 1'b0;
    logic        pstop_i = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_next_i_addr;
    logic        if_busy;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .if_pc_source(if_pc_source),
        .branch_addr(branch_addr), .jump_addr(jump_addr),
        .hazard(hazard), .pstop_i(pstop_i),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .IF_ID_instruction(IF_ID_instruction), .IF_ID_next_i_addr(IF_ID_next_i_addr),
        .if_busy(if_busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting to start, 1 = memory request outstanding, 2 = word held during stall
    int          m_phase;
    logic [31:0] m_pc, m_held, m_redir_addr, m_instr, m_nia;
    bit          m_redir_valid;

    task automatic model_reset();
        m_phase = 0; m_pc = 32'h0; m_held = 32'h0; m_redir_addr = 32'h0;
        m_redir_valid = 0; m_instr = 32'h0; m_nia = 32'h0;
    endtask

    task automatic model_step();
        bit          stop, taken, delivered;
        logic [31:0] target, dest, word;
        stop      = hazard || pstop_i;
        taken     = (if_pc_source == 2'd1) || (if_pc_source == 2'd2);
        target    = (if_pc_source == 2'd1) ? branch_addr : jump_addr;
        dest      = taken ? target : (m_redir_valid ? m_redir_addr : m_pc + 32'd4);
        delivered = 0;
        word      = 32'h0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack && !stop) begin delivered = 1; word = imem_rdata; end
            else if (imem_ack) begin m_held = imem_rdata; m_phase = 2; end
            else if (!stop) m_instr = 32'h0;
        end else if (!stop) begin
            delivered = 1; word = m_held; m_phase = 1;
        end
        if (delivered) begin
            m_instr = (FL && (taken || m_redir_valid)) ? 32'h0 : word;
            m_nia   = m_pc + 32'd4;
            m_pc    = dest;
            m_redir_valid = 0;
        end else if (taken && !pstop_i) begin
            m_redir_valid = 1;
            m_redir_addr  = target;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic hz, input logic ps, input logic [1:0] src,
                         input logic ack, input logic [31:0] rd, input logic [31:0] br, input logic [31:0] jp);
        rst = r; hazard = hz; pstop_i = ps; if_pc_source = src;
        imem_ack = ack; imem_rdata = rd; branch_addr = br; jump_addr = jp;
        if (r) model_reset();
        #1;
        chk("model_req",   {31'b0, imem_req}, {31'b0, m_phase == 1});
        chk("model_addr",  imem_addr, m_pc);
        chk("model_busy",  {31'b0, if_busy}, {31'b0, (m_phase == 1) && !ack});
        chk("model_instr", IF_ID_instruction, m_instr);
        chk("model_nia",   IF_ID_next_i_addr, m_nia);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        chk("model_instr_post", IF_ID_instruction, m_instr);
        chk("model_nia_post",   IF_ID_next_i_addr, m_nia);
    endtask

    typedef struct {
        logic        hz, ps;
        logic [1:0]  src;
        logic        ack;
        logic [31:0] rd, br, jp, e_addr;
        logic        e_req, e_busy;
        logic [31:0] e_instr, e_nia;
    } vec_t;

    function automatic vec_t v(input logic hz, input logic [1:0] src, input logic ack,
                               input logic [31:0] rd, input logic [31:0] tgt,
                               input logic [31:0] e_addr, input logic e_req, input logic e_busy,
                               input logic [31:0] e_instr, input logic [31:0] e_nia);
        vec_t t;
        t.hz = hz; t.ps = 1'b0; t.src = src; t.ack = ack; t.rd = rd;
        t.br = tgt; t.jp = tgt; t.e_addr = e_addr; t.e_req = e_req; t.e_busy = e_busy;
        t.e_instr = e_instr; t.e_nia = e_nia;
        return t;
    endfunction

    localparam logic [31:0] A = 32'hA000_0000;
    localparam logic [31:0] B = 32'hB000_0000;
    vec_t tbl[23];

    initial begin
        tbl[0]  = v(0, 0, 0, 0,      0,            32'h00, 0, 0, 32'h0,  32'h0);
        tbl[1]  = v(0, 0, 1, A + 0,  0,            32'h00, 1, 0, A + 0,  32'h04);
        tbl[2]  = v(0, 0, 1, A + 1,  0,            32'h04, 1, 0, A + 1,  32'h08);
        tbl[3]  = v(0, 0, 1, A + 2,  0,            32'h08, 1, 0, A + 2,  32'h0C);
        tbl[4]  = v(0, 0, 1, A + 3,  0,            32'h0C, 1, 0, A + 3,  32'h10);
        tbl[5]  = v(0, 0, 0, 32'hDEAD, 0,          32'h10, 1, 1, 32'h0,  32'h10);
        tbl[6]  = v(0, 0, 0, 32'hDEAD, 0,          32'h10, 1, 1, 32'h0,  32'h10);
        tbl[7]  = v(0, 0, 1, A + 4,  0,            32'h10, 1, 0, A + 4,  32'h14);
        tbl[8]  = v(0, 0, 1, A + 5,  0,            32'h14, 1, 0, A + 5,  32'h18);
        tbl[9]  = v(0, 0, 1, A + 6,  0,            32'h18, 1, 0, A + 6,  32'h1C);
        tbl[10] = v(0, 0, 1, A + 7,  0,            32'h1C, 1, 0, A + 7,  32'h20);
        tbl[11] = v(1, 0, 1, A + 8,  0,            32'h20, 1, 0, A + 7,  32'h20);
        tbl[12] = v(1, 0, 0, 32'hBEEF, 0,          32'h20, 0, 0, A + 7,  32'h20);
        tbl[13] = v(0, 0, 0, 32'hBEEF, 0,          32'h20, 0, 0, A + 8,  32'h24);
        tbl[14] = v(0, 0, 1, A + 9,  0,            32'h24, 1, 0, A + 9,  32'h28);
        tbl[15] = v(0, 2, 1, A + 10, 32'h40,       32'h28, 1, 0, FL ? 32'h0 : A + 10, 32'h2C);
        tbl[16] = v(0, 1, 0, 32'h0,  32'h100,      32'h40, 1, 1, 32'h0,  32'h2C);
        tbl[17] = v(0, 0, 0, 32'h0,  0,            32'h40, 1, 1, 32'h0,  32'h2C);
        tbl[18] = v(0, 0, 1, B + 0,  0,            32'h40, 1, 0, FL ? 32'h0 : B + 0, 32'h44);
        tbl[19] = v(0, 0, 1, B + 1,  0,            32'h100, 1, 0, B + 1, 32'h104);
        tbl[20] = v(0, 2, 1, B + 2,  32'hFFFF_FFFC, 32'h104, 1, 0, FL ? 32'h0 : B + 2, 32'h108);
        tbl[21] = v(0, 0, 1, B + 3,  0,            32'hFFFF_FFFC, 1, 0, B + 3, 32'h0);
        tbl[22] = v(0, 0, 0, 32'h0,  0,            32'h0, 1, 1, 32'h0,  32'h0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",   {31'b0, imem_req}, 32'h0);
        chk("reset_busy",  {31'b0, if_busy},  32'h0);
        chk("reset_addr",  imem_addr, 32'h0);
        chk("reset_instr", IF_ID_instruction, 32'h0);
        chk("reset_nia",   IF_ID_next_i_addr, 32'h0);

        for (int i = 0; i < 23; i++) begin
            apply(0, tbl[i].hz, tbl[i].ps, tbl[i].src, tbl[i].ack, tbl[i].rd, tbl[i].br, tbl[i].jp);
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_req", i),  {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_busy", i), {31'b0, if_busy},  {31'b0, tbl[i].e_busy});
            advance();
            chk($sformatf("tbl%0d_instr", i), IF_ID_instruction, tbl[i].e_instr);
            chk($sformatf("tbl%0d_nia", i),   IF_ID_next_i_addr, tbl[i].e_nia);
        end

        // Reset while a fetch is completing: the ack is lost and fetch restarts at RESET_PC
        apply(0, 0, 0, 0, 1, 32'h1234, 0, 0);
        advance();
        chk("pre_rst_addr", imem_addr, 32'h4);
        apply(1, 0, 0, 0, 1, 32'h5678, 0, 0);
        chk("rst_mid_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_mid_addr",  imem_addr, 32'h0);
        chk("rst_mid_instr", IF_ID_instruction, 32'h0);
        chk("rst_mid_nia",   IF_ID_next_i_addr, 32'h0);
        advance();
        apply(0, 0, 0, 0, 1, 32'h9999, 0, 0);
        chk("idle_ack_req", {31'b0, imem_req}, 32'h0);
        advance();
        chk("idle_ack_ignored", IF_ID_instruction, 32'h0);
        apply(0, 0, 0, 0, 0, 32'h0, 0, 0);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req",  {31'b0, imem_req}, 32'h1);
        advance();

        for (int i = 0; i < 1500; i++) begin
            logic       r, hz, ps, ack;
            logic [1:0] src;
            r   = ($urandom_range(0, 99) == 0);
            hz  = ($urandom_range(0, 4) == 0);
            ps  = ($urandom_range(0, 9) == 0);
            ack = $urandom_range(0, 1) == 1;
            src = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            apply(r, hz, ps, src, ack, $urandom(),
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom(), $urandom());
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
